add_sub_checker: RTL and testbench
==================================

// Module: add_sub_checker
// PURPOSE
//  Self-checking result sink for the 4-bit adder/subtractor. Accepts one {a, b, s, result} vector per
//  handshake. Recomputes the expected result with an internal golden model and counts pass/fail vectors.
//  Reports a final verdict when the driver requests end-of-test.
//  Sits downstream of the add_sub instance on the FPGA lab board; replaces $monitor-based eyeball checking.
// PARAMETERS
//  WIDTH   4   operand width; result is WIDTH+1 bits (MSB = carry-out)
//  CNT_W   8   width of pass/fail counters
// PORTS
//  clk          in   1         single clock, all state on posedge
//  rst          in   1         asynchronous, active-high reset
//  in_valid     in   1         vector presented on a/b/s/result
//  in_ready     out  1         checker can accept a vector this cycle
//  a            in   WIDTH     operand 1
//  b            in   WIDTH     operand 2
//  s            in   1         0 = add, 1 = subtract
//  result       in   WIDTH+1   DUT output {cout, sum}
//  done_req     in   1         request end-of-test verdict (level, held until test_done)
//  pass_cnt     out  CNT_W     vectors that matched
//  fail_cnt     out  CNT_W     vectors that mismatched
//  test_done    out  1         verdict valid (sticky until rst)
//  test_pass    out  1         valid when test_done: fail_cnt==0 && pass_cnt!=0
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, pass_cnt=0, fail_cnt=0, test_done=0, test_pass=0, capture regs=0.
//    Reset asserted mid-operation aborts immediately; no partial count survives.
//  Golden model: exp[WIDTH:0] = a + (b ^ {WIDTH{s}}) + s, computed as a WIDTH+1-bit unsigned sum.
//    Example: 1001-1010 gives 01111. Example: 0110-0100 gives 10010.
//  FSM states, encoded in add_sub_pkg:
//    IDLE:  in_ready=1.
//           in_valid=1: capture a, b, s and result into registers; go to CHECK.
//           else if done_req=1: go to DONE.
//           in_valid and done_req both high: the vector wins; done_req is honoured on the next IDLE cycle.
//    CHECK: in_ready=0. Compare captured result with exp.
//           Match: pass_cnt++. Mismatch: fail_cnt++. Go to IDLE.
//    DONE:  in_ready=0, test_done=1, test_pass registered on entry. Held until rst; in_valid ignored.
//  Throughput: 1 vector per 2 clocks. Counters update 2 edges after acceptance (capture edge, CHECK edge).
//  Counters saturate at all-ones; they never wrap.
//  Inputs are sampled only on the accept edge (in_valid & in_ready). Changes at other times are don't-care.
// CONFIGURATION
//  ADD_SUB_CHK_ERRLOG_EN
//    Defined: adds outputs err_valid (1), err_a (WIDTH), err_b (WIDTH), err_s (1),
//      err_got (WIDTH+1), err_exp (WIDTH+1).
//      On the first mismatch only, these latch the captured vector and exp, and err_valid is set to 1.
//      Later mismatches do not overwrite them. All are cleared by rst.
//    Undefined: these ports and registers do not exist; the counting behaviour is identical.
// STRUCTURE
//  add_sub_pkg holds:
//    - state localparams ST_IDLE=2'd0, ST_CHECK=2'd1, ST_DONE=2'd2
//    - default WIDTH and CNT_W
//    - function add_sub_exp(a, b, s) returning WIDTH+1 bits
//  Sub-module add_sub_ref: combinational golden model wrapping add_sub_exp. It is also reused by benches.
//  Top level contains only the FSM, capture registers, counters and the optional error log.
// TESTING
//  1 rst pulse mid-CHECK
//    -> all outputs return to reset values asynchronously; in_ready=1 after release.
//  2 Feed the seven lab vectors with correct results:
//    (1001,1010,1,01111) (0010,1100,1,00110) (0110,0100,1,10010) (0101,0011,0,01000)
//    (1001,0110,0,01111) (0110,1001,0,01111) (1000,1000,0,10000).
//    Then done_req -> pass_cnt=7, fail_cnt=0, test_done=1, test_pass=1.
//  3 Send (0101,0011,0,00111), then (1000,1000,0,00000)
//    -> fail_cnt=2, test_pass=0.
//    With ADD_SUB_CHK_ERRLOG_EN: err_got=00111, err_exp=01000, unchanged by the second mismatch.
//  4 in_valid held high continuously
//    -> in_ready toggles 1,0,1,0; exactly one vector is accepted per 2 cycles.
//  5 in_valid and done_req rise together
//    -> the vector is counted, then DONE. done_req with no vectors -> test_done=1, test_pass=0.
//  6 Force pass_cnt to 8'hFE, then send 3 passing vectors
//    -> pass_cnt sticks at 8'hFF.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared definitions for the add/sub result checker: FSM state encoding,
// default widths and the golden add/subtract function.
package add_sub_pkg;

    localparam int ADD_SUB_WIDTH = 4;
    localparam int ADD_SUB_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Two's-complement add/subtract: a + ~b + 1 when s=1, a + b when s=0.
    // MSB of the WIDTH+1 bit result is the carry-out.
    function automatic logic [ADD_SUB_WIDTH:0] add_sub_exp(
        input logic [ADD_SUB_WIDTH-1:0] a,
        input logic [ADD_SUB_WIDTH-1:0] b,
        input logic                     s
    );
        return {1'b0, a}
             + {1'b0, b ^ {ADD_SUB_WIDTH{s}}}
             + {{ADD_SUB_WIDTH{1'b0}}, s};
    endfunction

endpackage

// File: rtl/add_sub_ref.sv
// Combinational golden model for the 4-bit adder/subtractor.
// Uses the package function at the default width; other widths use the
// same expression inline so the module stays parameterizable.
module add_sub_ref
    import add_sub_pkg::*;
#(
    parameter int WIDTH = ADD_SUB_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH:0]   exp
);

    if (WIDTH == ADD_SUB_WIDTH) begin : g_pkg_fn
        assign exp = add_sub_exp(a, b, s);
    end else begin : g_inline
        assign exp = {1'b0, a} + {1'b0, b ^ {WIDTH{s}}} + {{WIDTH{1'b0}}, s};
    end

endmodule

// File: rtl/add_sub_checker.sv
// Self-checking result sink for the adder/subtractor. Captures one vector
// per handshake, checks it against add_sub_ref on the following cycle and
// keeps saturating pass/fail counts until end-of-test is requested.
// Optional first-mismatch log: define ADD_SUB_CHK_ERRLOG_EN.
module add_sub_checker
    import add_sub_pkg::*;
#(
    parameter int WIDTH = ADD_SUB_WIDTH,
    parameter int CNT_W = ADD_SUB_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    input  logic [WIDTH:0]   result,
    input  logic             done_req,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             test_done,
    output logic             test_pass
`ifdef ADD_SUB_CHK_ERRLOG_EN
    ,
    output logic             err_valid,
    output logic [WIDTH-1:0] err_a,
    output logic [WIDTH-1:0] err_b,
    output logic             err_s,
    output logic [WIDTH:0]   err_got,
    output logic [WIDTH:0]   err_exp
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic             cap_s;
    logic [WIDTH:0]   cap_result;
    logic [WIDTH:0]   exp;
    logic             match;

    // Golden model works on the captured vector so the inputs may change
    // freely after the accept edge.
    add_sub_ref #(.WIDTH(WIDTH)) u_ref (
        .a   (cap_a),
        .b   (cap_b),
        .s   (cap_s),
        .exp (exp)
    );

    assign match = (cap_result == exp);

    // Handshake FSM, capture registers, saturating counters and verdict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            cap_a      <= '0;
            cap_b      <= '0;
            cap_s      <= 1'b0;
            cap_result <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            test_done  <= 1'b0;
            test_pass  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A pending vector takes priority over the verdict
                    // request; done_req is seen again on the next IDLE cycle.
                    if (in_valid) begin
                        cap_a      <= a;
                        cap_b      <= b;
                        cap_s      <= s;
                        cap_result <= result;
                        in_ready   <= 1'b0;
                        state      <= ST_CHECK;
                    end else if (done_req) begin
                        in_ready  <= 1'b0;
                        test_done <= 1'b1;
                        test_pass <= (fail_cnt == '0) && (pass_cnt != '0);
                        state     <= ST_DONE;
                    end
                end
                ST_CHECK: begin
                    if (match) begin
                        if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_ONE;
                    end else begin
                        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_ONE;
                    end
                    in_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
                ST_DONE: begin
                    // Verdict is sticky until reset; further vectors ignored.
                    in_ready <= 1'b0;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ADD_SUB_CHK_ERRLOG_EN
    // Latch the first mismatching vector only; later mismatches are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_a     <= '0;
            err_b     <= '0;
            err_s     <= 1'b0;
            err_got   <= '0;
            err_exp   <= '0;
        end else if (state == ST_CHECK && !match && !err_valid) begin
            err_valid <= 1'b1;
            err_a     <= cap_a;
            err_b     <= cap_b;
            err_s     <= cap_s;
            err_got   <= cap_result;
            err_exp   <= exp;
        end
    end
`endif

endmodule

// File: tb/tb_add_sub_checker.sv
// Directed bench for add_sub_checker; expected values are hand-computed.
// Define ADD_SUB_CHK_ERRLOG_EN to also check the first-mismatch log.
module tb_add_sub_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       s = 1'b0;
    logic [4:0] result = '0;
    logic       done_req = 1'b0;
    logic [7:0] pass_cnt;
    logic [7:0] fail_cnt;
    logic       test_done;
    logic       test_pass;
`ifdef ADD_SUB_CHK_ERRLOG_EN
    logic       err_valid;
    logic [3:0] err_a;
    logic [3:0] err_b;
    logic       err_s;
    logic [4:0] err_got;
    logic [4:0] err_exp;
`endif

    int n_vec = 0;
    int n_err = 0;

    // {a, b, s, correct result}
    logic [13:0] lab [0:6] = '{
        {4'b1001, 4'b1010, 1'b1, 5'b01111},
        {4'b0010, 4'b1100, 1'b1, 5'b00110},
        {4'b0110, 4'b0100, 1'b1, 5'b10010},
        {4'b0101, 4'b0011, 1'b0, 5'b01000},
        {4'b1001, 4'b0110, 1'b0, 5'b01111},
        {4'b0110, 4'b1001, 1'b0, 5'b01111},
        {4'b1000, 4'b1000, 1'b0, 5'b10000}
    };

    add_sub_checker #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s         (s),
        .result    (result),
        .done_req  (done_req),
        .pass_cnt  (pass_cnt),
        .fail_cnt  (fail_cnt),
        .test_done (test_done),
        .test_pass (test_pass)
`ifdef ADD_SUB_CHK_ERRLOG_EN
        ,
        .err_valid (err_valid),
        .err_a     (err_a),
        .err_b     (err_b),
        .err_s     (err_s),
        .err_got   (err_got),
        .err_exp   (err_exp)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; done_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one vector at the next IDLE cycle; returns #1 after the CHECK
    // edge, when the counters have updated.
    task automatic send(input logic [13:0] v);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (w >= 8) chk("ready_timeout", {31'b0, in_ready}, 32'd1);
        {a, b, s, result} = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic request_done();
        @(negedge clk);
        done_req = 1'b1;
        @(posedge clk);
        #1;
        done_req = 1'b0;
    endtask

    initial begin
        // ---- reset values
        rst_pulse();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_pass", {24'b0, pass_cnt}, 32'd0);
        chk("rst_fail", {24'b0, fail_cnt}, 32'd0);
        chk("rst_done", {31'b0, test_done}, 32'd0);
        chk("rst_tpass", {31'b0, test_pass}, 32'd0);
`ifdef ADD_SUB_CHK_ERRLOG_EN
        chk("rst_err_valid", {31'b0, err_valid}, 32'd0);
`endif

        // ---- 1: reset mid-CHECK aborts the pending count
        @(negedge clk);
        {a, b, s, result} = lab[3];
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("t1_in_check_ready", {31'b0, in_ready}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("t1_async_ready", {31'b0, in_ready}, 32'd1);
        chk("t1_async_pass", {24'b0, pass_cnt}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t1_post_ready", {31'b0, in_ready}, 32'd1);
        chk("t1_post_pass", {24'b0, pass_cnt}, 32'd0);

        // ---- 2: seven correct lab vectors, then verdict
        for (int i = 0; i < 7; i++) begin
            send(lab[i]);
            chk("t2_pass_step", {24'b0, pass_cnt}, i + 1);
        end
        chk("t2_fail", {24'b0, fail_cnt}, 32'd0);
        chk("t2_done_before", {31'b0, test_done}, 32'd0);
        request_done();
        chk("t2_done", {31'b0, test_done}, 32'd1);
        chk("t2_tpass", {31'b0, test_pass}, 32'd1);
        chk("t2_ready_done", {31'b0, in_ready}, 32'd0);
        // DONE ignores further vectors
        @(negedge clk);
        {a, b, s, result} = lab[0];
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("t2_done_ignore", {24'b0, pass_cnt}, 32'd7);
        chk("t2_done_sticky", {31'b0, test_done}, 32'd1);

        // ---- 3: one pass then two mismatches
        rst_pulse();
        send(lab[0]);
        send({4'b0101, 4'b0011, 1'b0, 5'b00111});
        send({4'b1000, 4'b1000, 1'b0, 5'b00000});
        chk("t3_fail", {24'b0, fail_cnt}, 32'd2);
        chk("t3_pass", {24'b0, pass_cnt}, 32'd1);
`ifdef ADD_SUB_CHK_ERRLOG_EN
        chk("t3_err_valid", {31'b0, err_valid}, 32'd1);
        chk("t3_err_a", {28'b0, err_a}, 32'h5);
        chk("t3_err_b", {28'b0, err_b}, 32'h3);
        chk("t3_err_s", {31'b0, err_s}, 32'd0);
        chk("t3_err_got", {27'b0, err_got}, 32'h07);
        chk("t3_err_exp", {27'b0, err_exp}, 32'h08);
`endif
        request_done();
        chk("t3_done", {31'b0, test_done}, 32'd1);
        chk("t3_tpass", {31'b0, test_pass}, 32'd0);

        // ---- 4: in_valid held high, one accept every 2 cycles
        rst_pulse();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t4_ready_toggle", {31'b0, in_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i == 0) begin
                {a, b, s, result} = lab[3];
                in_valid = 1'b1;
            end
            if (i == 5) in_valid = 1'b0;
        end
        @(negedge clk);
        chk("t4_pass", {24'b0, pass_cnt}, 32'd3);
        chk("t4_ready_end", {31'b0, in_ready}, 32'd1);

        // ---- 5: in_valid and done_req together: vector first, then DONE
        rst_pulse();
        @(negedge clk);
        {a, b, s, result} = lab[6];
        in_valid = 1'b1;
        done_req = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t5_not_done_in_check", {31'b0, test_done}, 32'd0);
        @(negedge clk);
        chk("t5_counted", {24'b0, pass_cnt}, 32'd1);
        chk("t5_not_done_yet", {31'b0, test_done}, 32'd0);
        @(negedge clk);
        done_req = 1'b0;
        chk("t5_done", {31'b0, test_done}, 32'd1);
        chk("t5_tpass", {31'b0, test_pass}, 32'd1);
        // verdict request with no vectors
        rst_pulse();
        request_done();
        chk("t5_empty_done", {31'b0, test_done}, 32'd1);
        chk("t5_empty_tpass", {31'b0, test_pass}, 32'd0);

        // ---- 6: drive pass_cnt to FE, then saturate
        rst_pulse();
        for (int i = 0; i < 254; i++) send(lab[i % 7]);
        chk("t6_pass_fe", {24'b0, pass_cnt}, 32'hFE);
        send(lab[1]);
        chk("t6_pass_ff", {24'b0, pass_cnt}, 32'hFF);
        send(lab[2]);
        send(lab[4]);
        chk("t6_pass_sat", {24'b0, pass_cnt}, 32'hFF);
        chk("t6_fail", {24'b0, fail_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
